// File: rtl/mac_emu_pkg.sv
// rtl/mac_emu_pkg.sv - shared types and helpers for the MAC stream player
package mac_emu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    // MSB-first byte-enable mask in the low db bits; rem == 0 means a full beat
    function automatic logic [15:0] keep_mask(input int db, input int rem);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < db && (rem == 0 || i < rem)) begin
                m[db - 1 - i] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_stream_player_if.sv
// rtl/mac_stream_player_if.sv - stream bundle for the RX and TX sides
interface mac_stream_player_if #(
    parameter int DATA_BYTES = 4,
    parameter int USER_WIDTH = 16
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    // the sink only counts bytes and frames, so payload and tuser stay unseen
    modport slave  (input tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/mac_emu_ram.sv
// rtl/mac_emu_ram.sv - simple dual-port frame buffer, 1-cycle read latency
module mac_emu_ram #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);
    logic [WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // only the read register resets; the stored frame survives rst
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/mac_stream_player.sv
// rtl/mac_stream_player.sv - frame replay onto RX stream plus TX sink statistics
module mac_stream_player
    import mac_emu_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int LEN_WIDTH  = 16,
    parameter int IFG_WIDTH  = 8
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         buf_wr_en,
    input  logic [ADDR_WIDTH-$clog2(DATA_BYTES)-1:0]     buf_wr_addr,
    input  logic [8*DATA_BYTES-1:0]                      buf_wr_data,
    input  logic                                         start,
    input  logic [LEN_WIDTH-1:0]                         frame_len,
    input  logic [15:0]                                  repeat_cnt,
    input  logic [IFG_WIDTH-1:0]                         ifg,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         err,
    mac_stream_player_if.master                          m_axis,
    mac_stream_player_if.slave                           s_axis,
    input  logic [7:0]                                   tx_ready_pattern,
    output logic [31:0]                                  tx_frame_count,
    output logic [31:0]                                  tx_byte_count,
    output logic [LEN_WIDTH-1:0]                         tx_last_len
);
    localparam int KW  = $clog2(DATA_BYTES);
    localparam int WAW = ADDR_WIDTH - KW;

    state_t                  state, state_n;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [15:0]             rep_left;
    logic [IFG_WIDTH-1:0]    ifg_q, gap_cnt;
    logic [WAW-1:0]          cur_word, last_word, rd_addr;
    logic [8*DATA_BYTES-1:0] rd_data;
    logic                    err_q;
    logic                    accept, illegal, hs, is_last, sending;

    mac_emu_ram #(.WIDTH(8*DATA_BYTES), .ADDR_BITS(WAW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (buf_wr_en),
        .waddr (buf_wr_addr),
        .wdata (buf_wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign accept  = (state == S_IDLE) && start;
    assign illegal = (frame_len == '0) || (32'(frame_len) > (32'd1 << ADDR_WIDTH));
    assign sending = (state == S_SEND);
    assign hs      = sending && m_axis.tready;
    assign is_last = (cur_word == last_word);

    always_comb begin
        state_n = state;
        rd_addr = cur_word;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_FETCH;
            end
            // an illegal length still passes through here so err/busy lead done by a cycle
            S_FETCH: begin
                busy    = 1'b1;
                rd_addr = '0;
                state_n = err_q ? S_DONE : S_SEND;
            end
            S_SEND: begin
                busy = 1'b1;
                if (hs) begin
                    rd_addr = cur_word + 1'b1;
                    if (is_last) begin
                        if (rep_left != '0) state_n = (ifg_q != '0) ? S_GAP : S_FETCH;
                        else                state_n = S_DONE;
                    end
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (gap_cnt == IFG_WIDTH'(1)) state_n = S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            rep_left  <= '0;
            ifg_q     <= '0;
            gap_cnt   <= '0;
            cur_word  <= '0;
            last_word <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                len_q     <= frame_len;
                rep_left  <= repeat_cnt;
                ifg_q     <= ifg;
                err_q     <= illegal;
                last_word <= WAW'((frame_len - 1'b1) >> KW);
            end
            if (state == S_FETCH) cur_word <= '0;
            if (hs) begin
                cur_word <= cur_word + 1'b1;
                if (is_last && rep_left != '0) begin
                    rep_left <= rep_left - 1'b1;
                    gap_cnt  <= ifg_q;
                end
            end
            if (state == S_GAP) gap_cnt <= gap_cnt - 1'b1;
        end
    end

    assign err           = err_q;
    assign m_axis.tvalid = sending;
    assign m_axis.tlast  = sending && is_last;
    assign m_axis.tdata  = sending ? rd_data : '0;
    assign m_axis.tuser  = sending ? len_q : '0;
    assign m_axis.tkeep  = !sending ? '0 :
                           is_last  ? DATA_BYTES'(keep_mask(DATA_BYTES, int'(len_q) % DATA_BYTES)) : '1;

    logic [7:0]  pat_q, pat_prev;
    logic [31:0] acc, beat_bytes;
    logic        tx_hs;

    assign s_axis.tready = pat_q[0];
    assign tx_hs         = s_axis.tvalid && pat_q[0];
    assign beat_bytes    = 32'(popcount16(16'(s_axis.tkeep)));

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q          <= tx_ready_pattern;
            pat_prev       <= tx_ready_pattern;
            acc            <= '0;
            tx_frame_count <= '0;
            tx_byte_count  <= '0;
            tx_last_len    <= '0;
        end else begin
            pat_prev <= tx_ready_pattern;
            if (tx_ready_pattern != pat_prev) pat_q <= tx_ready_pattern;
            else                              pat_q <= {pat_q[0], pat_q[7:1]};
            if (tx_hs) begin
                tx_byte_count <= tx_byte_count + beat_bytes;
                if (s_axis.tlast) begin
                    tx_frame_count <= tx_frame_count + 1'b1;
                    tx_last_len    <= LEN_WIDTH'(acc + beat_bytes);
                    acc            <= '0;
                end else begin
                    acc <= acc + beat_bytes;
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_stream_player.sv
// tb/tb_mac_stream_player.sv - directed self-checking bench for mac_stream_player
module tb_mac_stream_player;
    logic        clk = 1'b0;
    logic        rst, buf_wr_en, start;
    logic [11:0] buf_wr_addr;
    logic [31:0] buf_wr_data;
    logic [15:0] frame_len, repeat_cnt;
    logic [7:0]  ifg, tx_ready_pattern;
    logic        busy, done, err;
    logic [31:0] tx_frame_count, tx_byte_count;
    logic [15:0] tx_last_len;

    int vectors = 0;
    int miscompares = 0;

    int          n_beats, n_frames, done_delay;
    logic [31:0] first_tdata, last_tdata;
    logic [3:0]  last_tkeep;
    logic        last_tlast;
    logic [15:0] last_tuser;
    int          gaps[$];

    mac_stream_player_if #(.DATA_BYTES(4), .USER_WIDTH(16)) m_if ();
    mac_stream_player_if #(.DATA_BYTES(4), .USER_WIDTH(16)) s_if ();

    mac_stream_player dut (
        .clk              (clk),
        .rst              (rst),
        .buf_wr_en        (buf_wr_en),
        .buf_wr_addr      (buf_wr_addr),
        .buf_wr_data      (buf_wr_data),
        .start            (start),
        .frame_len        (frame_len),
        .repeat_cnt       (repeat_cnt),
        .ifg              (ifg),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .m_axis           (m_if),
        .s_axis           (s_if),
        .tx_ready_pattern (tx_ready_pattern),
        .tx_frame_count   (tx_frame_count),
        .tx_byte_count    (tx_byte_count),
        .tx_last_len      (tx_last_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    endfunction

    task automatic do_play(input int len, input int rep, input int gap, input bit rnd);
        int          bif, idle, last_hs, exp_beats;
        bit          in_gap, stalled;
        logic [31:0] h_data;
        logic [3:0]  h_keep;
        logic        h_last;
        logic [15:0] h_user;
        exp_beats = (len + 3) / 4;
        bif = 0; idle = 0; last_hs = -100; in_gap = 0; stalled = 0;
        h_data = '0; h_keep = '0; h_last = 1'b0; h_user = '0;
        n_beats = 0; n_frames = 0; done_delay = -1;
        gaps.delete();
        frame_len = 16'(len); repeat_cnt = 16'(rep); ifg = 8'(gap);
        m_if.tready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_n1", busy, 1);
        chk("err_cleared", err, 0);
        chk("valid_n1", m_if.tvalid, 0);
        tick();
        chk("valid_n2", m_if.tvalid, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) m_if.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                done_delay = cyc - last_hs;
                break;
            end
            if (stalled) begin
                chk("stall_tdata", m_if.tdata, h_data);
                chk("stall_tkeep", m_if.tkeep, h_keep);
                chk("stall_tlast", m_if.tlast, h_last);
                chk("stall_tuser", m_if.tuser, h_user);
            end
            stalled = 0;
            if (m_if.tvalid) begin
                if (in_gap) begin
                    gaps.push_back(idle);
                    in_gap = 0;
                end
                if (m_if.tready) begin
                    chk("payload", m_if.tdata, exp_word(bif));
                    chk("tuser", m_if.tuser, 64'(len));
                    chk("tlast_pos", m_if.tlast, (bif == exp_beats - 1));
                    if (n_beats == 0) first_tdata = m_if.tdata;
                    last_tdata = m_if.tdata;
                    last_tkeep = m_if.tkeep;
                    last_tlast = m_if.tlast;
                    last_tuser = m_if.tuser;
                    n_beats++;
                    last_hs = cyc;
                    if (m_if.tlast) begin
                        n_frames++;
                        bif = 0;
                        in_gap = 1;
                        idle = 0;
                    end else begin
                        bif++;
                    end
                end else begin
                    stalled = 1;
                    h_data = m_if.tdata; h_keep = m_if.tkeep;
                    h_last = m_if.tlast; h_user = m_if.tuser;
                end
            end else if (in_gap) begin
                idle++;
            end
            tick();
        end
        chk("done_seen", (done_delay >= 0), 1);
        chk("busy_at_done", busy, 0);
        m_if.tready = 1'b1;
        tick();
        chk("done_pulse_len", done, 0);
    endtask

    task automatic tx_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int w;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l;
        for (w = 0; w < 20; w++) begin
            if (s_if.tready) break;
            tick();
        end
        if (w == 20) chk("tx_ready_timeout", 0, 1);
        tick();
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic tx_frame(input int len);
        int beats;
        beats = (len + 3) / 4;
        for (int b = 0; b < beats; b++) begin
            if (b == beats - 1) begin
                case (len % 4)
                    1: tx_beat(exp_word(b), 4'b1000, 1'b1);
                    2: tx_beat(exp_word(b), 4'b1100, 1'b1);
                    3: tx_beat(exp_word(b), 4'b1110, 1'b1);
                    default: tx_beat(exp_word(b), 4'b1111, 1'b1);
                endcase
            end else begin
                tx_beat(exp_word(b), 4'b1111, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; buf_wr_en = 1'b0; buf_wr_addr = '0; buf_wr_data = '0;
        start = 1'b0; frame_len = '0; repeat_cnt = '0; ifg = '0;
        tx_ready_pattern = 8'b0101_0101;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
        tick();
        tick();
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_tkeep", m_if.tkeep, 0);
        chk("rst_tuser", m_if.tuser, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_counts", {tx_frame_count, tx_byte_count}, 0);
        chk("rst_last_len", tx_last_len, 0);
        chk("rst_tready", s_if.tready, 1);
        rst = 1'b0;
        tick();
        chk("pattern_rot", s_if.tready, 0);

        for (int w = 0; w < 16; w++) begin
            buf_wr_en = 1'b1; buf_wr_addr = 12'(w); buf_wr_data = exp_word(w);
            tick();
        end
        buf_wr_en = 1'b0;

        do_play(60, 0, 0, 0);
        chk("f60_beats", n_beats, 15);
        chk("f60_first", first_tdata, 32'h0001_0203);
        chk("f60_last", last_tdata, 32'h3839_3A3B);
        chk("f60_keep", last_tkeep, 4'b1111);
        chk("f60_tlast", last_tlast, 1);
        chk("f60_tuser", last_tuser, 16'd60);
        chk("f60_done_delay", done_delay, 1);

        do_play(61, 0, 0, 0);
        chk("f61_beats", n_beats, 16);
        chk("f61_keep", last_tkeep, 4'b1000);
        do_play(62, 0, 0, 0);
        chk("f62_keep", last_tkeep, 4'b1100);
        do_play(63, 0, 0, 0);
        chk("f63_keep", last_tkeep, 4'b1110);
        chk("f63_last", last_tdata, 32'h3C3D_3E3F);

        do_play(8, 2, 5, 0);
        chk("rep_frames", n_frames, 3);
        chk("rep_beats", n_beats, 6);
        chk("rep_gap_count", gaps.size(), 2);
        chk("rep_gap0", gaps[0], 6);
        chk("rep_gap1", gaps[1], 6);

        do_play(8, 1, 0, 0);
        chk("ifg0_gap", gaps[0], 1);

        do_play(60, 0, 0, 1);
        chk("rnd_beats", n_beats, 15);
        chk("rnd_last", last_tdata, 32'h3839_3A3B);

        frame_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 1);
        chk("len0_done_n1", done, 0);
        chk("len0_valid_n1", m_if.tvalid, 0);
        tick();
        chk("len0_done_n2", done, 1);
        chk("len0_valid_n2", m_if.tvalid, 0);
        tick();
        chk("len0_idle", {busy, done, err}, 3'b001);

        frame_len = 16'd16385; start = 1'b1;
        tick();
        start = 1'b0;
        chk("big_err", err, 1);
        chk("big_busy", busy, 1);
        tick();
        chk("big_done", done, 1);
        chk("big_valid", m_if.tvalid, 0);
        tick();

        do_play(8, 0, 0, 0);
        chk("after_err_beats", n_beats, 2);

        tx_frame(60);
        chk("tx1_frames", tx_frame_count, 1);
        chk("tx1_bytes", tx_byte_count, 60);
        chk("tx1_len", tx_last_len, 60);
        tx_frame(61);
        chk("tx2_frames", tx_frame_count, 2);
        chk("tx2_bytes", tx_byte_count, 121);
        chk("tx2_len", tx_last_len, 61);

        tx_beat(32'hAABB_CCDD, 4'b1111, 1'b0);
        tx_beat(32'hAABB_CCDD, 4'b1111, 1'b0);
        frame_len = 16'd60; repeat_cnt = '0; ifg = '0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_valid", m_if.tvalid, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", m_if.tvalid, 0);
        chk("mid_rst_tlast", m_if.tlast, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_counts", {tx_frame_count, tx_byte_count}, 0);
        chk("mid_rst_len", tx_last_len, 0);
        rst = 1'b0;
        tick();

        do_play(8, 0, 0, 0);
        chk("kept_beats", n_beats, 2);
        tx_frame(8);
        chk("tx3_frames", tx_frame_count, 1);
        chk("tx3_bytes", tx_byte_count, 8);
        chk("tx3_len", tx_last_len, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mac_stream_player.md
# mac_stream_player

Synthesizable, parametrised MAC traffic player/capturer for simulation benches and on-board loopback. Holds a frame image in an internal byte buffer and replays it as AXI-Stream RX traffic, with big-endian byte order, MSB-first `tkeep`, and frame length on `tuser`. Adds repeat count, inter-frame gap and an error flag. Its TX side sinks AXI-Stream traffic with a programmable back-pressure pattern and keeps frame/byte statistics. It sits in place of a MAC, between the fabric and the design under test.

## Interface
- `DATA_BYTES`, 4: bytes per beat; power of two, 1..16.
- `ADDR_WIDTH`, 14: byte-address width of the frame buffer; depth is 2^ADDR_WIDTH bytes.
- `LEN_WIDTH`, 16: frame length width; also the width of `tuser`.
- `IFG_WIDTH`, 8: inter-frame gap counter width.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `buf_wr_en`  in  1  write one word into the buffer.
- `buf_wr_addr`  in  ADDR_WIDTH-log2(DATA_BYTES)  word address.
- `buf_wr_data`  in  8*DATA_BYTES  word data; byte 0 in the MSBs.
- `start`  in  1  single-cycle pulse that begins playback.
- `frame_len`  in  LEN_WIDTH  bytes per frame; sampled at `start`.
- `repeat_cnt`  in  16  extra copies to send; total frames = `repeat_cnt` + 1.
- `ifg`  in  IFG_WIDTH  idle cycles between frames.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when playback ends.
- `err`  out  1  sticky; set on an illegal `frame_len`; cleared by the next accepted `start`.
- `m_axis_tdata/tkeep/tuser/tvalid/tlast`  out  8*DATA_BYTES/DATA_BYTES/LEN_WIDTH/1/1  RX stream.
- `m_axis_tready`  in  1.
- `s_axis_tdata/tkeep/tvalid/tlast`  in  8*DATA_BYTES/DATA_BYTES/1/1  TX stream.
- `s_axis_tready`  out  1.
- `tx_ready_pattern`  in  8  back-pressure pattern, rotated one bit per cycle.
- `tx_frame_count`  out  32  count of completed TX frames.
- `tx_byte_count`  out  32  count of accepted TX bytes.
- `tx_last_len`  out  LEN_WIDTH  byte length of the most recent TX frame.

## Operation
- Buffer:
  - Simple dual-port: word-wide write port, synchronous read with 1-cycle latency.
  - Writes during playback are allowed; the result is undefined only for words being replayed.
- Player FSM states: IDLE, FETCH, SEND, GAP, DONE.
  - IDLE: `start` latches `frame_len`, `repeat_cnt` and `ifg`, then goes to FETCH.
  - `start` is ignored when not in IDLE.
  - `frame_len` = 0 or `frame_len` > 2^ADDR_WIDTH: set `err` and go to DONE; no beats are sent.
  - FETCH: issue a read of word 0; go to SEND.
  - SEND: present beat k.
    - Advance to the next beat only on `tvalid && tready`, prefetching word k+1.
    - On the last beat, `tlast` = 1.
    - `tkeep` = top r bits set, where r = `frame_len` mod DATA_BYTES, or all ones when r = 0.
    - All other beats have `tkeep` all ones.
    - `tuser` = latched `frame_len` on every beat.
  - After the last beat:
    - If frames remain, go to GAP when `ifg` > 0, else to FETCH.
    - Otherwise go to DONE.
  - GAP: count `ifg` cycles with `tvalid` = 0, then go to FETCH.
  - DONE: pulse `done` for one cycle, drop `busy`, return to IDLE.
- Beat count = ceil(`frame_len` / DATA_BYTES). Addresses restart at word 0 for every repeat.
- AXI rule: while `tvalid` is high and `tready` is low, `tdata/tkeep/tuser/tlast` hold stable.
- TX sink:
  - `s_axis_tready` = `tx_ready_pattern[0]` of a rotating copy; the copy reloads from the input whenever the input changes.
  - On each handshake, bytes += popcount(`tkeep`), added to `tx_byte_count` and to a frame accumulator.
  - On a `tlast` handshake: `tx_frame_count` +1; `tx_last_len` = accumulator including this beat; accumulator cleared.
  - Counters wrap modulo 2^32.

## Timing
- Reset values:
  - `tvalid`, `tlast`, `busy`, `done`, `err` = 0.
  - `tdata`, `tkeep`, `tuser` = 0.
  - Counters = 0; rotating pattern = `tx_ready_pattern`.
- Latency: `start` at cycle N gives `busy` at N+1 and the first `tvalid` at N+2.
- With `tready` held high there is one beat per cycle, and no bubble between beats of a frame.
- Between frames with `ifg` = 0 there is exactly 1 idle cycle (FETCH).
- `done` arrives 1 cycle after the last handshake.
- Illegal-length `start`: `err` and `busy` assert at N+1, `done` pulses at N+2.
- `rst` mid-frame: `tvalid` is 0 from the next edge; the frame is truncated without `tlast`; buffer contents are kept.
- TX counters update on the edge after the handshake.

## Structure
- Shared package `mac_emu_pkg`:
  - FSM state encoding.
  - `tkeep` generation function (remainder to MSB-first mask).
  - Popcount function.
- Sub-module `mac_emu_ram`: parametrised simple dual-port RAM, width 8*DATA_BYTES, depth 2^(ADDR_WIDTH)/DATA_BYTES, read latency 1.

## Test plan
- DATA_BYTES=4: load bytes 00..3B, `frame_len`=60, `tready`=1 -> 15 beats; first `tdata`=00010203; last `tdata`=38393A3B with `tkeep`=1111 and `tlast`; `tuser`=60; `done` 1 cycle later.
- `frame_len`=61, 62, 63 -> 16 beats; last `tkeep` = 1000, 1100, 1110 respectively.
- `repeat_cnt`=2, `ifg`=5, `frame_len`=8 -> 3 frames of 2 beats each, 6 idle cycles between frames; `busy` drops after the third frame.
- Random `tready` (50%) -> payload identical to the `tready`=1 run; `tdata` stable during every stall.
- `frame_len`=0, then `frame_len`=16385 -> `err`=1, `done` pulse, no `tvalid`; the next valid `start` clears `err`.
- TX: `tx_ready_pattern`=8'b01010101; send frames of 60 B and 61 B -> `tx_frame_count`=2, `tx_byte_count`=121, `tx_last_len`=61; assert `rst` mid-frame -> all zero.
